// File: rtl/poly_horner_seq_if.sv
// Host-side bus of the sequential Horner polynomial evaluator:
// coefficient write port, start/x request and busy/done/sum/ovf status.
interface poly_horner_seq_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 32
);
    logic          coeff_wr_en;
    logic [3:0]    coeff_wr_addr;
    logic [DW-1:0] coeff_wr_data;
    logic          start;
    logic [DW-1:0] x;
    logic          busy;
    logic          done;
    logic [AW-1:0] sum;
    logic          ovf;

    modport master (
        output coeff_wr_en, coeff_wr_addr, coeff_wr_data, start, x,
        input  busy, done, sum, ovf
    );

    modport slave (
        input  coeff_wr_en, coeff_wr_addr, coeff_wr_data, start, x,
        output busy, done, sum, ovf
    );
endinterface

// File: rtl/poly_horner_seq.sv
// Sequential polynomial evaluator: Horner's scheme on one shared multiply-accumulate,
// one coefficient per clock. Owns a DEGREE+1 entry coefficient file written from the bus
// while idle. Optional overflow detection is built when POLY_OVF_DETECT_EN is defined;
// otherwise ovf is tied low.
module poly_horner_seq #(
    parameter int unsigned DEGREE = 10,
    parameter int unsigned DW     = 16,
    parameter int unsigned AW     = 32
) (
    input logic              clk,
    input logic              rst_n,
    poly_horner_seq_if.slave bus
);

    localparam int unsigned   IW     = (DEGREE < 1) ? 1 : $clog2(DEGREE + 1);
    localparam logic [IW-1:0] TopIdx = IW'(DEGREE);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    function automatic logic [AW-1:0] sext(input logic [DW-1:0] c);
        return {{(AW - DW){c[DW-1]}}, c};
    endfunction

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [DW-1:0] x_q, x_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [AW-1:0] sum_q, sum_d;
    logic [DW-1:0] coeff_q [DEGREE+1];

    // Pre-write copy of a coefficient overwritten on the same edge that starts a run.
    logic          save_valid_q, save_valid_d;
    logic [IW-1:0] save_addr_q, save_addr_d;
    logic [DW-1:0] save_data_q, save_data_d;

    logic          start_ok;
    logic          wr_ok;
    logic [IW-1:0] wr_idx;
    logic [DW-1:0] c_rd;
    logic [AW+DW-1:0] prod;
    logic [AW+DW-1:0] exact;

    // Write/start qualification and the coefficient read for the current RUN step.
    always_comb begin
        start_ok = (state_q == StIdle) && bus.start;
        wr_idx   = bus.coeff_wr_addr[IW-1:0];
        wr_ok    = bus.coeff_wr_en && (state_q == StIdle)
                   && ({28'd0, bus.coeff_wr_addr} <= DEGREE);
        c_rd     = (save_valid_q && (save_addr_q == idx_q)) ? save_data_q : coeff_q[idx_q];
    end

    // Full-width signed MAC; sign-extended operands make the truncated product exact.
    always_comb begin
        prod  = {{DW{acc_q[AW-1]}}, acc_q} * {{AW{x_q[DW-1]}}, x_q};
        exact = prod + {{AW{c_rd[DW-1]}}, c_rd};
    end

    // FSM and datapath next-state.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        x_d          = x_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        save_valid_d = save_valid_q;
        save_addr_d  = save_addr_q;
        save_data_d  = save_data_q;
        case (state_q)
            StIdle: begin
                if (start_ok) begin
                    x_d          = bus.x;
                    acc_d        = sext(coeff_q[TopIdx]);
                    idx_d        = TopIdx - IW'(1);
                    save_valid_d = wr_ok;
                    save_addr_d  = wr_idx;
                    save_data_d  = coeff_q[wr_idx];
                    if (DEGREE == 0) begin
                        sum_d   = sext(coeff_q[TopIdx]);
                        state_d = StDone;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                acc_d = exact[AW-1:0];
                idx_d = idx_q - IW'(1);
                if (idx_q == '0) begin
                    sum_d   = exact[AW-1:0];
                    state_d = StDone;
                end
            end
            StDone: begin
                save_valid_d = 1'b0;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            x_q          <= '0;
            idx_q        <= '0;
            sum_q        <= '0;
            save_valid_q <= 1'b0;
            save_addr_q  <= '0;
            save_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            x_q          <= x_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            save_valid_q <= save_valid_d;
            save_addr_q  <= save_addr_d;
            save_data_q  <= save_data_d;
        end
    end

    // Coefficient file; writes only land while idle and in range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= int'(DEGREE); i++) begin
                coeff_q[i] <= '0;
            end
        end else if (wr_ok) begin
            coeff_q[wr_idx] <= bus.coeff_wr_data;
        end
    end

`ifdef POLY_OVF_DETECT_EN
    logic ovf_run_q, ovf_run_d;
    logic ovf_q, ovf_d;
    logic step_ovf;

    // A step overflows when the exact result's bits above the AW-bit sign disagree.
    // The running flag restarts on each accepted start; the visible flag is
    // published with sum so the pair stays stable between evaluations.
    always_comb begin
        step_ovf  = !((&exact[AW+DW-1:AW-1]) || !(|exact[AW+DW-1:AW-1]));
        ovf_run_d = ovf_run_q;
        ovf_d     = ovf_q;
        if (start_ok) begin
            ovf_run_d = 1'b0;
            if (DEGREE == 0) begin
                ovf_d = 1'b0;
            end
        end else if (state_q == StRun) begin
            ovf_run_d = ovf_run_q | step_ovf;
            if (idx_q == '0) begin
                ovf_d = ovf_run_q | step_ovf;
            end
        end
    end

    // Overflow flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_run_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            ovf_run_q <= ovf_run_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    logic unused_exact_hi;
    assign unused_exact_hi = ^exact[AW+DW-1:AW];
    assign bus.ovf         = 1'b0;
`endif

    assign bus.busy = (state_q != StIdle);
    assign bus.done = (state_q == StDone);
    assign bus.sum  = sum_q;

endmodule

// File: tb/tb_poly_horner_seq.sv
// Directed self-checking bench for poly_horner_seq (DEGREE=10, DW=16, AW=32).
module tb_poly_horner_seq;

    localparam int unsigned DEGREE = 10;
    localparam int unsigned DW     = 16;
    localparam int unsigned AW     = 32;

`ifdef POLY_OVF_DETECT_EN
    localparam logic OvfBig = 1'b1;
`else
    localparam logic OvfBig = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    poly_horner_seq_if #(.DW(DW), .AW(AW)) bus ();

    poly_horner_seq #(
        .DEGREE (DEGREE),
        .DW     (DW),
        .AW     (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int k, input logic [15:0] v);
        bus.coeff_wr_en   = 1'b1;
        bus.coeff_wr_addr = 4'(k);
        bus.coeff_wr_data = v;
        @(negedge clk);
        bus.coeff_wr_en   = 1'b0;
    endtask

    task automatic set_all(input logic [15:0] v);
        for (int k = 0; k <= int'(DEGREE); k++) wr(k, v);
    endtask

    // Start at a negedge, run to done, check latency/busy/sum/ovf and the return to idle.
    task automatic eval(input string tag, input logic [15:0] xv, input logic [31:0] exp_sum,
                        input logic exp_ovf, input bit interfere, input bit sim_wr,
                        input logic [15:0] sim_data);
        int cyc;
        int busy_cnt;
        bus.start = 1'b1;
        bus.x     = xv;
        if (sim_wr) begin
            bus.coeff_wr_en   = 1'b1;
            bus.coeff_wr_addr = 4'd0;
            bus.coeff_wr_data = sim_data;
        end
        @(negedge clk);
        bus.start       = 1'b0;
        bus.coeff_wr_en = 1'b0;
        bus.x           = 16'h5a5a;
        cyc      = 1;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (interfere && cyc == 3) begin
                bus.start         = 1'b1;
                bus.coeff_wr_en   = 1'b1;
                bus.coeff_wr_addr = 4'd0;
                bus.coeff_wr_data = 16'd100;
            end else begin
                bus.start       = 1'b0;
                bus.coeff_wr_en = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start       = 1'b0;
        bus.coeff_wr_en = 1'b0;
        if (bus.busy === 1'b1) busy_cnt++;
        check({tag, ".latency"}, 64'(cyc), 64'd11);
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd11);
        check({tag, ".sum"}, 64'(bus.sum), 64'(exp_sum));
        check({tag, ".ovf"}, 64'(bus.ovf), 64'(exp_ovf));
        @(negedge clk);
        check({tag, ".done_low"}, 64'(bus.done), 64'd0);
        check({tag, ".idle"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int done_seen;
        rst_n             = 1'b0;
        bus.coeff_wr_en   = 1'b0;
        bus.coeff_wr_addr = '0;
        bus.coeff_wr_data = '0;
        bus.start         = 1'b0;
        bus.x             = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.busy", 64'(bus.busy), 64'd0);
        check("rst.done", 64'(bus.done), 64'd0);
        check("rst.sum", 64'(bus.sum), 64'd0);
        check("rst.ovf", 64'(bus.ovf), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        eval("zero", 16'd7, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0);

        set_all(16'd1);
        eval("ones", 16'd2, 32'd2047, 1'b0, 1'b0, 1'b0, 16'd0);

        set_all(16'd0);
        wr(0, 16'hfffb);
        eval("neg5", 16'd1234, 32'hffff_fffb, 1'b0, 1'b0, 1'b0, 16'd0);

        for (int k = 0; k <= int'(DEGREE); k++) wr(k, 16'(k));
        eval("alt", 16'hffff, 32'd5, 1'b0, 1'b0, 1'b0, 16'd0);

        // start and write during RUN are both ignored
        eval("interfere", 16'hffff, 32'd5, 1'b0, 1'b1, 1'b0, 16'd0);
        wr(0, 16'd100);
        eval("c0_100", 16'hffff, 32'd105, 1'b0, 1'b0, 1'b0, 16'd0);

        // 16^10 = 2^40 wraps to 0
        set_all(16'd0);
        wr(10, 16'd1);
        eval("x16", 16'd16, 32'd0, OvfBig, 1'b0, 1'b0, 16'd0);

        // Write alongside start commits, but this run uses the old c[0]; back-to-back next run
        wr(10, 16'd0);
        wr(0, 16'd3);
        eval("simul", 16'd1, 32'd3, 1'b0, 1'b0, 1'b1, 16'd9);
        eval("after", 16'd1, 32'd9, 1'b0, 1'b0, 1'b0, 16'd0);

        // Reset in the 5th RUN cycle
        bus.start = 1'b1;
        bus.x     = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.busy", 64'(bus.busy), 64'd0);
        check("midrst.done", 64'(bus.done), 64'd0);
        check("midrst.sum", 64'(bus.sum), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        check("midrst.no_done", 64'(done_seen), 64'd0);
        eval("post_rst", 16'd7, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
